// File: rtl/ddr3_emif_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_emif_arbiter
// Brief    : Two-port arbiter in front of the DDR3 EMIF Avalon-MM port.
//            Port 0 (pattern fetch, read only) has priority. Port 1
//            (loader/host, read and write) has an anti-starvation guarantee.
//            Write bursts hold the grant until the last beat. Read bursts are
//            tagged with their owner so return beats reach the right port.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_emif_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 256,
  parameter int BURST_W    = 5,
  parameter int TAG_DEPTH  = 8,
  parameter int MAX_STARVE = 16
) (
  input  logic                  ddr3_emif_clk,
  input  logic                  ddr3_emif_rst_n,
  input  logic                  m0_read,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [BURST_W-1:0]    m0_burst,
  output logic                  m0_ready,
  output logic                  m0_rddata_valid,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [BURST_W-1:0]    m1_burst,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  output logic                  m1_ready,
  output logic                  m1_rddata_valid,
  output logic [DATA_W-1:0]     m_rddata,
  input  logic                  ddr3_emif_ready,
  output logic                  ddr3_emif_read,
  output logic                  ddr3_emif_write,
  output logic [ADDR_W-1:0]     ddr3_emif_addr,
  output logic [BURST_W-1:0]    ddr3_emif_burst_count,
  output logic [DATA_W-1:0]     ddr3_emif_write_data,
  output logic [DATA_W/8-1:0]   ddr3_emif_byte_enable,
  input  logic [DATA_W-1:0]     ddr3_emif_read_data,
  input  logic                  ddr3_emif_rddata_valid
);

  localparam int                 c_PTR_W   = $clog2(TAG_DEPTH) + 1;
  localparam int                 c_STV_W   = $clog2(MAX_STARVE + 1);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(MAX_STARVE);
  localparam logic [c_STV_W-1:0] c_STV_ONE = c_STV_W'(1);
  localparam logic [BURST_W-1:0] c_ONE     = BURST_W'(1);

  typedef enum logic [0:0] {
    ARB     = 1'b0,
    WR_LOCK = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic                 r_tag_owner [TAG_DEPTH];
  logic [BURST_W-1:0]   r_tag_burst [TAG_DEPTH];
  logic [BURST_W-1:0]   r_ret_cnt;
  logic [BURST_W-1:0]   r_beat_cnt;
  logic [BURST_W-1:0]   r_wr_burst;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [c_STV_W-1:0]   r_starve;
  logic                 r_err_orphan;

  logic                 w_tag_empty;
  logic                 w_tag_full;
  logic [BURST_W-1:0]   w_m0_burst;
  logic [BURST_W-1:0]   w_m1_burst;
  logic                 w_m0_elig;
  logic                 w_m1_req;
  logic                 w_m1_elig;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_m0_acc;
  logic                 w_m1_acc;
  logic                 w_push;
  logic                 w_head_owner;
  logic [BURST_W-1:0]   w_head_burst;
  logic                 w_ret_hit;
  logic                 w_ret_last;

  // Tag FIFO status uses the extra pointer bit to tell full from empty.
  assign w_tag_empty  = (r_wptr == r_rptr);
  assign w_tag_full   = (r_wptr[c_PTR_W-1] != r_rptr[c_PTR_W-1]) &&
                        (r_wptr[c_PTR_W-2:0] == r_rptr[c_PTR_W-2:0]);
  assign w_head_owner = r_tag_owner[r_rptr[c_PTR_W-2:0]];
  assign w_head_burst = r_tag_burst[r_rptr[c_PTR_W-2:0]];

  // A burstcount of zero behaves as a single beat.
  assign w_m0_burst = (m0_burst == '0) ? c_ONE : m0_burst;
  assign w_m1_burst = (m1_burst == '0) ? c_ONE : m1_burst;

  // Reads cannot be issued without a free tag slot; writes need none.
  assign w_m0_elig = m0_read && !w_tag_full;
  assign w_m1_req  = m1_read || m1_write;
  assign w_m1_elig = m1_write || (m1_read && !w_tag_full);

  assign w_m0_acc  = w_gnt0 && ddr3_emif_ready;
  assign w_m1_acc  = w_gnt1 && ddr3_emif_ready;
  assign w_push    = ddr3_emif_read && ddr3_emif_ready;

  // Return beats are only meaningful while a burst is outstanding.
  assign w_ret_hit  = ddr3_emif_rddata_valid && !w_tag_empty;
  assign w_ret_last = w_ret_hit && (r_ret_cnt == (w_head_burst - c_ONE));

  assign m0_rddata_valid = w_ret_hit && !w_head_owner;
  assign m1_rddata_valid = w_ret_hit &&  w_head_owner;
  assign m_rddata        = ddr3_emif_read_data;

  // State register for the arbitration / write-lock FSM.
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n) r_state <= ARB;
    else                  r_state <= w_state_nxt;
  end

  // Grant selection, next state and the combinational command mux.
  always_comb begin
    w_state_nxt           = r_state;
    w_gnt0                = 1'b0;
    w_gnt1                = 1'b0;
    if (ddr3_emif_rst_n) begin
      case (r_state)
        ARB: begin
          if ((r_starve == c_STV_MAX) && w_m1_elig) w_gnt1 = 1'b1;
          else if (w_m0_elig)                       w_gnt0 = 1'b1;
          else if (w_m1_elig)                       w_gnt1 = 1'b1;
          if (w_gnt1 && m1_write && ddr3_emif_ready && (w_m1_burst != c_ONE))
            w_state_nxt = WR_LOCK;
        end
        WR_LOCK: begin
          w_gnt1 = m1_write;
          if (m1_write && ddr3_emif_ready && (r_beat_cnt == c_ONE))
            w_state_nxt = ARB;
        end
        default: w_state_nxt = ARB;
      endcase
    end
    ddr3_emif_read        = w_gnt0 || (w_gnt1 && m1_read);
    ddr3_emif_write       = w_gnt1 && m1_write;
    m0_ready              = w_gnt0 && ddr3_emif_ready;
    m1_ready              = w_gnt1 && ddr3_emif_ready;
    ddr3_emif_write_data  = m1_wdata;
    ddr3_emif_byte_enable = m1_be;
    if (w_gnt0) begin
      ddr3_emif_addr        = m0_addr;
      ddr3_emif_burst_count = w_m0_burst;
    end else if (r_state == WR_LOCK) begin
      ddr3_emif_addr        = r_wr_addr;
      ddr3_emif_burst_count = r_wr_burst;
    end else begin
      ddr3_emif_addr        = m1_addr;
      ddr3_emif_burst_count = w_m1_burst;
    end
  end

  // Write-burst bookkeeping: latch first-beat addr/burst, count remaining beats.
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n) begin
      r_beat_cnt <= '0;
      r_wr_burst <= '0;
      r_wr_addr  <= '0;
    end else if (w_m1_acc && m1_write) begin
      if (r_state == ARB) begin
        r_beat_cnt <= w_m1_burst - c_ONE;
        r_wr_burst <= w_m1_burst;
        r_wr_addr  <= m1_addr;
      end else begin
        r_beat_cnt <= r_beat_cnt - c_ONE;
      end
    end
  end

  // Starvation counter: counts port-0 wins while port 1 waits.
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n)                     r_starve <= '0;
    else if (!w_m1_req || w_m1_acc)           r_starve <= '0;
    else if (w_m0_acc && (r_starve != c_STV_MAX)) r_starve <= r_starve + c_STV_ONE;
  end

  // Tag FIFO pointers, return-beat counter and the sticky orphan flag.
  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ret_cnt    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_ret_last) begin
        r_rptr    <= r_rptr + c_PTR_W'(1);
        r_ret_cnt <= '0;
      end else if (w_ret_hit) begin
        r_ret_cnt <= r_ret_cnt + c_ONE;
      end
      if (ddr3_emif_rddata_valid && w_tag_empty) r_err_orphan <= 1'b1;
    end
  end

  // Tag FIFO storage; contents are qualified by the pointers.
  always_ff @(posedge ddr3_emif_clk) begin
    if (w_push) begin
      r_tag_owner[r_wptr[c_PTR_W-2:0]] <= w_gnt1;
      r_tag_burst[r_wptr[c_PTR_W-2:0]] <= ddr3_emif_burst_count;
    end
  end

endmodule
`default_nettype wire
